mux_tree_ccff_cfg: RTL and testbench

Parametrised N-input routing multiplexer with its configuration memory built in. Select bits load serially from the configuration-chain (ccff) shift path and take effect only on an explicit commit into a shadow register, so the datapath never glitches during programming. Drops into routing and LUT-input positions wherever a fixed 2-input mux basis cell plus external memory is used today. Cells chain head-to-tail with neighbouring configuration flops.

---
 rtl/mux_tree_ccff_cfg.sv | 131 +++++++++++++
 tb/tb_mux_tree_ccff_cfg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_ccff_cfg.sv
// mux_tree_ccff_cfg
//   N_IN-input routing multiplexer with built-in configuration memory.
//   Select bits shift in serially on the ccff chain and only reach the
//   datapath when a commit copies the shift register into a shadow register,
//   so `out` never glitches while the chain is being programmed.
//
// Parameters
//   N_IN     number of data inputs (2..64)
//   REG_OUT  0: combinational out, 1: out registered on prog_clk
//   MEM_W    select width, derived from N_IN (not overridable)
//
// Ports
//   prog_clk    configuration / output clock, rising edge
//   pReset_n    asynchronous active-low reset
//   in          data inputs; in[0] selected after reset
//   ccff_head   serial configuration bit in
//   ccff_en     shift enable for the configuration chain
//   cfg_commit  request to copy shift register into shadow register
//   ccff_tail   serial bit out to the next cell (shift register MSB)
//   mem         active select value (shadow register)
//   mem_inv     bitwise complement of mem
//   out         selected data bit
//   cfg_ready   at least MEM_W bits shifted since last commit or reset
//   cfg_err     sticky: commit requested while cfg_ready was low
module mux_tree_ccff_cfg #(
  parameter  int N_IN    = 4,
  parameter  int REG_OUT = 0,
  localparam int MEM_W   = $clog2(N_IN)
) (
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic [N_IN-1:0]  in,
  input  logic             ccff_head,
  input  logic             ccff_en,
  input  logic             cfg_commit,
  output logic             ccff_tail,
  output logic [MEM_W-1:0] mem,
  output logic [MEM_W-1:0] mem_inv,
  output logic             out,
  output logic             cfg_ready,
  output logic             cfg_err
);

  localparam int CNT_W = $clog2(MEM_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_W);

  if (N_IN < 2 || N_IN > 64) begin : g_bad_n_in
    $error("mux_tree_ccff_cfg: N_IN must be in 2..64");
  end

  logic [MEM_W-1:0] sreg;
  logic [MEM_W-1:0] sreg_next;
  logic [MEM_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             commit_ok;
  logic             commit_bad;
  logic             out_c;

  // Single-bit memory has nothing to shift through; the head loads directly.
  if (MEM_W == 1) begin : g_shift_1
    assign sreg_next = ccff_head;
  end else begin : g_shift_n
    assign sreg_next = {sreg[MEM_W-2:0], ccff_head};
  end

  assign cfg_ready  = (cnt == CNT_FULL);
  assign commit_ok  = cfg_commit && cfg_ready;
  assign commit_bad = cfg_commit && !cfg_ready;

  // An accepted commit restarts the count; a shift on the same edge is the
  // first bit of the next configuration, so the count restarts at 1.
  always_comb begin
    cnt_next = cnt;
    if (commit_ok) begin
      cnt_next = ccff_en ? CNT_W'(1) : '0;
    end else if (ccff_en && (cnt != CNT_FULL)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sreg    <= '0;
      shadow  <= '0;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (ccff_en) begin
        sreg <= sreg_next;
      end
      // Shadow takes the pre-shift value even when a shift happens together.
      if (commit_ok) begin
        shadow <= sreg;
      end
      if (commit_bad) begin
        cfg_err <= 1'b1;
      end
      cnt <= cnt_next;
    end
  end

  // Codes at or above N_IN match no input and yield 0.
  always_comb begin
    out_c = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (shadow == MEM_W'(i)) begin
        out_c = in[i];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic out_q;
    always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
        out_q <= 1'b0;
      end else begin
        out_q <= out_c;
      end
    end
    assign out = out_q;
  end else begin : g_comb_out
    assign out = out_c;
  end

  assign ccff_tail = sreg[MEM_W-1];
  assign mem       = shadow;
  assign mem_inv   = ~shadow;

endmodule

// File: tb/tb_mux_tree_ccff_cfg.sv
// Directed bench for mux_tree_ccff_cfg: a 6-input combinational cell, a
// two-cell 4-input chain and a 6-input registered-output cell.
module tb_mux_tree_ccff_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  // Cell A: N_IN=6, REG_OUT=0
  logic [5:0] a_in = '0;
  logic a_head = 1'b0, a_en = 1'b0, a_commit = 1'b0;
  logic a_tail, a_out, a_ready, a_err;
  logic [2:0] a_mem, a_mem_inv;

  mux_tree_ccff_cfg #(.N_IN(6), .REG_OUT(0)) u_a (
    .prog_clk(clk), .pReset_n(rst_n), .in(a_in), .ccff_head(a_head),
    .ccff_en(a_en), .cfg_commit(a_commit), .ccff_tail(a_tail), .mem(a_mem),
    .mem_inv(a_mem_inv), .out(a_out), .cfg_ready(a_ready), .cfg_err(a_err)
  );

  // Chain: two N_IN=4 cells, tail of c1 feeds head of c2
  logic [3:0] c_in = '0;
  logic c_head = 1'b0, c_en = 1'b0, c_commit = 1'b0;
  logic c1_tail, c1_out, c1_ready, c1_err;
  logic c2_tail, c2_out, c2_ready, c2_err;
  logic [1:0] c1_mem, c1_mem_inv, c2_mem, c2_mem_inv;

  mux_tree_ccff_cfg #(.N_IN(4), .REG_OUT(0)) u_c1 (
    .prog_clk(clk), .pReset_n(rst_n), .in(c_in), .ccff_head(c_head),
    .ccff_en(c_en), .cfg_commit(c_commit), .ccff_tail(c1_tail), .mem(c1_mem),
    .mem_inv(c1_mem_inv), .out(c1_out), .cfg_ready(c1_ready), .cfg_err(c1_err)
  );

  mux_tree_ccff_cfg #(.N_IN(4), .REG_OUT(0)) u_c2 (
    .prog_clk(clk), .pReset_n(rst_n), .in(c_in), .ccff_head(c1_tail),
    .ccff_en(c_en), .cfg_commit(c_commit), .ccff_tail(c2_tail), .mem(c2_mem),
    .mem_inv(c2_mem_inv), .out(c2_out), .cfg_ready(c2_ready), .cfg_err(c2_err)
  );

  // Cell R: N_IN=6, REG_OUT=1
  logic [5:0] r_in = '0;
  logic r_head = 1'b0, r_en = 1'b0, r_commit = 1'b0;
  logic r_tail, r_out, r_ready, r_err;
  logic [2:0] r_mem, r_mem_inv;

  mux_tree_ccff_cfg #(.N_IN(6), .REG_OUT(1)) u_r (
    .prog_clk(clk), .pReset_n(rst_n), .in(r_in), .ccff_head(r_head),
    .ccff_en(r_en), .cfg_commit(r_commit), .ccff_tail(r_tail), .mem(r_mem),
    .mem_inv(r_mem_inv), .out(r_out), .cfg_ready(r_ready), .cfg_err(r_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_in = 6'b000001;
    r_in = 6'b000001;
    #3 rst_n = 1'b0;
    #1;
    vec++; if (a_mem !== 3'b000) begin miss++; $display("FAIL reset_mem: got %b expected 000", a_mem); end
    vec++; if (a_mem_inv !== 3'b111) begin miss++; $display("FAIL reset_mem_inv: got %b expected 111", a_mem_inv); end
    vec++; if (a_tail !== 1'b0) begin miss++; $display("FAIL reset_tail: got %b expected 0", a_tail); end
    vec++; if (a_ready !== 1'b0) begin miss++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    vec++; if (a_err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b expected 0", a_err); end
    vec++; if (a_out !== 1'b1) begin miss++; $display("FAIL reset_out_in0: got %b expected 1", a_out); end
    vec++; if (r_out !== 1'b0) begin miss++; $display("FAIL reset_regout: got %b expected 0", r_out); end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_commit();
    logic [2:0] bits;
    logic [2:0] tails;
    bits  = 3'b101;   // shifted MSB-first: 1,0,1
    tails = 3'b001;   // tail after shift 1,2,3 (sreg 001, 010, 101)
    a_in = 6'b000001;
    for (int i = 2; i >= 0; i--) begin
      a_head = bits[i];
      a_en = 1'b1;
      step();
      vec++; if (a_out !== 1'b1) begin miss++; $display("FAIL shift_out_in0[%0d]: got %b expected 1", i, a_out); end
      vec++; if (a_mem !== 3'b000) begin miss++; $display("FAIL shift_mem_hold[%0d]: got %b expected 000", i, a_mem); end
      vec++; if (a_tail !== tails[i]) begin miss++; $display("FAIL shift_tail[%0d]: got %b expected %b", i, a_tail, tails[i]); end
    end
    a_en = 1'b0;
    vec++; if (a_ready !== 1'b1) begin miss++; $display("FAIL load_ready: got %b expected 1", a_ready); end
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    vec++; if (a_mem !== 3'b101) begin miss++; $display("FAIL commit_mem: got %b expected 101", a_mem); end
    vec++; if (a_mem_inv !== 3'b010) begin miss++; $display("FAIL commit_mem_inv: got %b expected 010", a_mem_inv); end
    vec++; if (a_ready !== 1'b0) begin miss++; $display("FAIL commit_ready_clr: got %b expected 0", a_ready); end
    vec++; if (a_out !== 1'b0) begin miss++; $display("FAIL commit_out_in5_lo: got %b expected 0", a_out); end
    a_in = 6'b100000;
    #1;
    vec++; if (a_out !== 1'b1) begin miss++; $display("FAIL commit_out_in5_hi: got %b expected 1", a_out); end
    a_in = 6'b011111;
    #1;
    vec++; if (a_out !== 1'b0) begin miss++; $display("FAIL commit_out_in5_others: got %b expected 0", a_out); end
  endtask

  task automatic test_early_commit();
    a_head = 1'b0;
    a_en = 1'b1;
    step();
    step();
    a_en = 1'b0;
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    vec++; if (a_err !== 1'b1) begin miss++; $display("FAIL early_err: got %b expected 1", a_err); end
    vec++; if (a_mem !== 3'b101) begin miss++; $display("FAIL early_mem_hold: got %b expected 101", a_mem); end
    vec++; if (a_ready !== 1'b0) begin miss++; $display("FAIL early_ready: got %b expected 0", a_ready); end
    a_head = 1'b1;
    a_en = 1'b1;
    step(); step(); step();
    a_en = 1'b0;
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    vec++; if (a_mem !== 3'b111) begin miss++; $display("FAIL oor_mem: got %b expected 111", a_mem); end
    vec++; if (a_err !== 1'b1) begin miss++; $display("FAIL err_sticky: got %b expected 1", a_err); end
    a_in = 6'b111111;
    #1;
    vec++; if (a_out !== 1'b0) begin miss++; $display("FAIL oor_out_ones: got %b expected 0", a_out); end
    a_in = 6'b101010;
    #1;
    vec++; if (a_out !== 1'b0) begin miss++; $display("FAIL oor_out_mixed: got %b expected 0", a_out); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] bits;
    bits = 3'b010;
    a_en = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      a_head = bits[i];
      step();
    end
    a_head = 1'b1;
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    vec++; if (a_mem !== 3'b010) begin miss++; $display("FAIL simul_mem: got %b expected 010", a_mem); end
    vec++; if (a_tail !== 1'b1) begin miss++; $display("FAIL simul_tail: got %b expected 1", a_tail); end
    vec++; if (a_ready !== 1'b0) begin miss++; $display("FAIL simul_ready: got %b expected 0", a_ready); end
    // cnt restarted at 1: one more shift leaves it short, the second fills it
    a_head = 1'b0;
    step();
    vec++; if (a_ready !== 1'b0) begin miss++; $display("FAIL simul_cnt2: got %b expected 0", a_ready); end
    step();
    a_en = 1'b0;
    vec++; if (a_ready !== 1'b1) begin miss++; $display("FAIL simul_cnt3: got %b expected 1", a_ready); end
    a_commit = 1'b1;
    step();
    a_commit = 1'b0;
    vec++; if (a_mem !== 3'b100) begin miss++; $display("FAIL simul_sreg_mem: got %b expected 100", a_mem); end
    a_in = 6'b010000;
    #1;
    vec++; if (a_out !== 1'b1) begin miss++; $display("FAIL simul_out_in4: got %b expected 1", a_out); end
  endtask

  task automatic test_chain();
    logic [3:0] bits;
    bits = 4'b1001;
    c_en = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      c_head = bits[i];
      step();
    end
    c_en = 1'b0;
    vec++; if (c2_ready !== 1'b1) begin miss++; $display("FAIL chain_ready2: got %b expected 1", c2_ready); end
    c_commit = 1'b1;
    step();
    c_commit = 1'b0;
    vec++; if (c1_mem !== 2'b01) begin miss++; $display("FAIL chain_mem1: got %b expected 01", c1_mem); end
    vec++; if (c2_mem !== 2'b10) begin miss++; $display("FAIL chain_mem2: got %b expected 10", c2_mem); end
    c_in = 4'b0010;
    #1;
    vec++; if (c1_out !== 1'b1) begin miss++; $display("FAIL chain_out1: got %b expected 1", c1_out); end
    vec++; if (c2_out !== 1'b0) begin miss++; $display("FAIL chain_out2: got %b expected 0", c2_out); end
  endtask

  task automatic test_regout_reset();
    logic [2:0] bits;
    bits = 3'b010;
    r_in = 6'b000100;
    step();
    r_en = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      r_head = bits[i];
      step();
    end
    r_en = 1'b0;
    r_commit = 1'b1;
    step();
    r_commit = 1'b0;
    vec++; if (r_mem !== 3'b010) begin miss++; $display("FAIL reg_commit_mem: got %b expected 010", r_mem); end
    vec++; if (r_out !== 1'b0) begin miss++; $display("FAIL reg_commit_out_lat: got %b expected 0", r_out); end
    step();
    vec++; if (r_out !== 1'b1) begin miss++; $display("FAIL reg_commit_out: got %b expected 1", r_out); end
    r_in = 6'b000001;
    #1;
    vec++; if (r_out !== 1'b1) begin miss++; $display("FAIL reg_data_hold: got %b expected 1", r_out); end
    step();
    vec++; if (r_out !== 1'b0) begin miss++; $display("FAIL reg_data_lat: got %b expected 0", r_out); end
    // reset in the middle of a shift sequence
    a_in = 6'b000001;
    r_head = 1'b1;
    r_en = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    vec++; if (r_out !== 1'b0) begin miss++; $display("FAIL midrst_out: got %b expected 0", r_out); end
    vec++; if (r_mem !== 3'b000) begin miss++; $display("FAIL midrst_mem: got %b expected 000", r_mem); end
    vec++; if (r_mem_inv !== 3'b111) begin miss++; $display("FAIL midrst_mem_inv: got %b expected 111", r_mem_inv); end
    vec++; if (r_tail !== 1'b0) begin miss++; $display("FAIL midrst_tail: got %b expected 0", r_tail); end
    vec++; if (a_out !== 1'b1) begin miss++; $display("FAIL midrst_a_out: got %b expected 1", a_out); end
    vec++; if (a_err !== 1'b0) begin miss++; $display("FAIL midrst_err_clr: got %b expected 0", a_err); end
    @(negedge clk);
    r_en = 1'b0;
    rst_n = 1'b1;
    step();
    vec++; if (r_out !== 1'b1) begin miss++; $display("FAIL postrst_out_in0: got %b expected 1", r_out); end
    vec++; if (r_ready !== 1'b0) begin miss++; $display("FAIL postrst_ready: got %b expected 0", r_ready); end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_early_commit();
    test_simultaneous();
    test_chain();
    test_regout_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
